stream_arb_m: RTL and testbench

STREAM_ARB_M -- requirements
Module: stream_arb_m

---
 rtl/stream_arb_m_pkg.sv | 40 ++++
 rtl/stream_arb_m_rr_pick.sv | 32 +++
 rtl/stream_arb_m.sv | 129 ++++++++++++
 tb/tb_stream_arb_m.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_m_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_m_pkg
// Shared helpers for the stream arbiter family. Nothing in here depends on the
// arbiter's N parameter. Requests are zero-extended up to RR_MAX_N bits and the
// live width is passed in as an argument.
//   rr_pick_t      : {any, idx} result of a round-robin search
//   rr_find_first  : first set request strictly after ptr, wrapping modulo n
// -----------------------------------------------------------------------------
package stream_arb_m_pkg;

    localparam int RR_MAX_N   = 16;
    localparam int RR_MAX_IDX = 4;

    typedef struct packed {
        logic                  any;
        logic [RR_MAX_IDX-1:0] idx;
    } rr_pick_t;

    // Scan candidates ptr+1, ptr+2, ... ptr+n (mod n). ptr < n, so the sum is
    // below 2n and a single conditional subtract replaces a modulo.
    function automatic rr_pick_t rr_find_first(
        input logic [RR_MAX_N-1:0]   req,
        input logic [RR_MAX_IDX-1:0] ptr,
        input int                    n
    );
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 1; k <= RR_MAX_N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= n) cand = cand - n;
            if (k <= n && !pick.any && req[cand[RR_MAX_IDX-1:0]]) begin
                pick.any = 1'b1;
                pick.idx = cand[RR_MAX_IDX-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/stream_arb_m_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick_m
// Combinational round-robin picker. It returns the first asserted request
// searching upward from ptr+1, wrapping at N.
//   req [N]     in  : request vector
//   ptr [IDX_W] in  : index of the previous winner
//   any         out : at least one request is asserted
//   idx [IDX_W] out : winning index (valid only when any=1)
// -----------------------------------------------------------------------------
module rr_pick_m
    import stream_arb_m_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [RR_MAX_N-1:0]   w_req;
    logic [RR_MAX_IDX-1:0] w_ptr;
    rr_pick_t              w_pick;

    assign w_req  = RR_MAX_N'(req);
    assign w_ptr  = RR_MAX_IDX'(ptr);
    assign w_pick = rr_find_first(w_req, w_ptr, N);
    assign any    = w_pick.any;
    assign idx    = w_pick.idx[IDX_W-1:0];

endmodule

// File: rtl/stream_arb_m.sv
// -----------------------------------------------------------------------------
// stream_arb_m
// Packet-level round-robin arbiter. It merges N valid/ready source streams into
// one registered output stream. A granted source keeps the grant until its
// last beat is accepted. One IDLE bubble separates consecutive packets.
//   clk, rst          : clock, synchronous active-high reset
//   valid_src/ready_src/src/last_src [N] : source beat handshake and payload
//   valid_dst/ready_dst : output handshake
//   dst, last_dst, idx_dst : registered output beat, end marker, source index
//   busy              : a packet is currently locked
// -----------------------------------------------------------------------------
module stream_arb_m
    import stream_arb_m_pkg::*;
#(
    parameter int  N      = 4,
    parameter type DATA_T = logic,
    parameter int  IDX_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     valid_src,
    output logic [N-1:0]     ready_src,
    input  DATA_T [N-1:0]    src,
    input  logic [N-1:0]     last_src,
    output logic             valid_dst,
    input  logic             ready_dst,
    output DATA_T            dst,
    output logic             last_dst,
    output logic [IDX_W-1:0] idx_dst,
    output logic             busy
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_ptr;
    logic             r_full;
    DATA_T            r_dst;
    logic             r_last;
    logic [IDX_W-1:0] r_idx;

    logic             w_any;
    logic [IDX_W-1:0] w_win;
    logic             w_src_rdy;
    logic             w_accept;
    logic             w_beat_last;
    logic             w_lock;
    logic             w_release;

    rr_pick_m #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req (valid_src),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_win)
    );

    // The output register can take a beat when it is empty or draining this
    // cycle. Only the granted source ever sees ready.
    assign w_src_rdy   = (r_state == ST_LOCKED) && (!r_full || ready_dst);
    assign ready_src   = w_src_rdy ? (N'(1) << r_grant) : '0;
    assign w_accept    = w_src_rdy && valid_src[r_grant];
    assign w_beat_last = last_src[r_grant];

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_lock      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_LOCKED;
                    w_lock      = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                    w_release   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ptr resets to N-1 so the first search starts at source 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_ptr   <= IDX_W'(N - 1);
            r_full  <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            if (w_lock)    r_grant <= w_win;
            if (w_release) r_ptr   <= r_grant;
            if (w_accept) begin
                r_full <= 1'b1;
                r_idx  <= r_grant;
                r_last <= w_beat_last;
            end else if (ready_dst) begin
                r_full <= 1'b0;
            end
        end
    end

    // NOTE: the payload register is deliberately left out of reset. valid_dst
    // qualifies it, so resetting the wide data path would buy nothing.
    always_ff @(posedge clk) begin
        if (w_accept) r_dst <= src[r_grant];
    end

    assign valid_dst = r_full;
    assign dst       = r_dst;
    assign last_dst  = r_last;
    assign idx_dst   = r_idx;
    assign busy      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_stream_arb_m.sv
// -----------------------------------------------------------------------------
// tb_stream_arb_m
// Directed bench for stream_arb_m with N=4 and 8-bit beats. Each scenario loads
// per-source beat lists and pushes the hand-ordered expected output beats into
// a scoreboard queue. A negedge monitor pops and compares every beat that
// leaves on dst.
// -----------------------------------------------------------------------------
module tb_stream_arb_m;

    localparam int N = 4;

    typedef logic [7:0] data_t;
    typedef struct packed { data_t d; logic l; } beat_t;
    typedef struct packed { data_t d; logic l; logic [1:0] idx; } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  valid_src;
    logic [N-1:0]  ready_src;
    data_t [N-1:0] src;
    logic [N-1:0]  last_src;
    logic          valid_dst;
    logic          ready_dst;
    data_t         dst;
    logic          last_dst;
    logic [1:0]    idx_dst;
    logic          busy;

    int total = 0;
    int bad   = 0;

    beat_t      mem [N][8];
    int         wr  [N];
    int         rd  [N];
    logic [N-1:0] hold;
    exp_t       exp_q [$];

    stream_arb_m #(.N(N), .DATA_T(data_t)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_src (valid_src),
        .ready_src (ready_src),
        .src       (src),
        .last_src  (last_src),
        .valid_dst (valid_dst),
        .ready_dst (ready_dst),
        .dst       (dst),
        .last_dst  (last_dst),
        .idx_dst   (idx_dst),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i]) begin
                valid_src[i] = !hold[i];
                src[i]       = mem[i][rd[i]].d;
                last_src[i]  = mem[i][rd[i]].l;
            end else begin
                valid_src[i] = 1'b0;
                src[i]       = '0;
                last_src[i]  = 1'b0;
            end
        end
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
        hold = '0;
    endtask

    task automatic push(input int s, input data_t d, input logic l);
        mem[s][wr[s]] = '{d: d, l: l};
        wr[s]++;
    endtask

    task automatic expect_beat(input data_t d, input logic l, input logic [1:0] idx);
        exp_q.push_back('{d: d, l: l, idx: idx});
    endtask

    // One clock: the handshake is sampled mid-cycle, sources advance after the
    // edge, and outputs settle before control returns.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = valid_src & ready_src;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) rd[i]++;
        drive();
        #1;
    endtask

    task automatic run(input int n, output logic [15:0] bz, output logic [15:0] vd);
        bz = '0;
        vd = '0;
        for (int k = 0; k < n; k++) begin
            step();
            bz[k] = busy;
            vd[k] = valid_dst;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        drive();
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        check(nm, exp_q.size(), 0);
        step();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (valid_dst === 1'b1 && ready_dst === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dst data", dst, e.d);
                check("dst last", last_dst, e.l);
                check("dst idx", idx_dst, e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bz, vd;
        int          ok;

        rst       = 1'b1;
        ready_dst = 1'b1;
        flush();
        drive();
        do_reset();

        // Reset state
        check("reset valid_dst", valid_dst, 0);
        check("reset busy", busy, 0);
        check("reset idx_dst", idx_dst, 0);
        check("reset last_dst", last_dst, 0);
        check("reset ready_src", ready_src, 0);

        // src1 alone: 3-beat packet on consecutive cycles, busy for 3 cycles
        push(1, 8'hA1, 1'b0); push(1, 8'hB2, 1'b0); push(1, 8'hC3, 1'b1);
        expect_beat(8'hA1, 1'b0, 2'd1);
        expect_beat(8'hB2, 1'b0, 2'd1);
        expect_beat(8'hC3, 1'b1, 2'd1);
        drive(); #1;
        check("s1 idle ready_src", ready_src, 0);
        run(8, bz, vd);
        check("s1 busy pattern", bz, 16'h0007);
        check("s1 valid pattern", vd, 16'h000E);
        check("s1 drained", exp_q.size(), 0);

        // All sources with 1-beat packets after reset: 0,1,2,3,0 with bubbles
        do_reset();
        push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
        push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
        expect_beat(8'h10, 1'b1, 2'd0);
        expect_beat(8'h11, 1'b1, 2'd1);
        expect_beat(8'h12, 1'b1, 2'd2);
        expect_beat(8'h13, 1'b1, 2'd3);
        expect_beat(8'h14, 1'b1, 2'd0);
        drive(); #1;
        run(12, bz, vd);
        check("s2 busy pattern", bz, 16'h0155);
        check("s2 valid pattern", vd, 16'h02AA);
        check("s2 drained", exp_q.size(), 0);

        // src0 stalls for 5 cycles mid-packet while src2 waits: no preemption
        do_reset();
        push(0, 8'h20, 1'b0); push(0, 8'h21, 1'b0); push(0, 8'h22, 1'b1);
        push(2, 8'h2F, 1'b1);
        expect_beat(8'h20, 1'b0, 2'd0);
        expect_beat(8'h21, 1'b0, 2'd0);
        expect_beat(8'h22, 1'b1, 2'd0);
        expect_beat(8'h2F, 1'b1, 2'd2);
        drive(); #1;
        step();
        step();
        hold[0] = 1'b1;
        drive(); #1;
        ok = 0;
        vd = '0;
        for (int k = 0; k < 5; k++) begin
            if (ready_src == 4'b0001 && busy) ok++;
            if (k > 0) vd[k] = valid_dst;
            if (k < 4) step();
        end
        check("s3 grant held", ok, 5);
        check("s3 no output in gap", vd, 0);
        hold[0] = 1'b0;
        drive(); #1;
        wait_drain("s3 drained");

        // ready_dst low for 4 cycles with a full output register
        push(1, 8'h40, 1'b0); push(1, 8'h41, 1'b1);
        expect_beat(8'h40, 1'b0, 2'd1);
        expect_beat(8'h41, 1'b1, 2'd1);
        drive(); #1;
        step();
        check("s4 lock ready_src", ready_src, 4'b0010);
        step();
        ready_dst = 1'b0;
        #1;
        ok = 0;
        for (int k = 0; k < 4; k++) begin
            if (ready_src == 4'b0000 && valid_dst && dst == 8'h40 && idx_dst == 2'd1) ok++;
            step();
        end
        check("s4 stall stable", ok, 4);
        ready_dst = 1'b1;
        #1;
        check("s4 release ready_src", ready_src, 4'b0010);
        step();
        check("s4 next beat dst", dst, 8'h41);
        check("s4 next beat last", last_dst, 1);
        wait_drain("s4 drained");

        // Reset during the 2nd beat of a 4-beat packet
        push(2, 8'h50, 1'b0); push(2, 8'h51, 1'b0);
        push(2, 8'h52, 1'b0); push(2, 8'h53, 1'b1);
        expect_beat(8'h50, 1'b0, 2'd2);
        drive(); #1;
        step();
        step();
        rst = 1'b1;
        #1;
        step();
        check("s5 valid_dst after rst", valid_dst, 0);
        check("s5 busy after rst", busy, 0);
        check("s5 idx_dst after rst", idx_dst, 0);
        check("s5 last_dst after rst", last_dst, 0);
        rst = 1'b0;
        flush();
        drive(); #1;
        check("s5 ready_src after rst", ready_src, 0);
        check("s5 held beat dropped", exp_q.size(), 0);
        push(0, 8'h60, 1'b1); push(3, 8'h63, 1'b1);
        expect_beat(8'h60, 1'b1, 2'd0);
        expect_beat(8'h63, 1'b1, 2'd3);
        drive(); #1;
        wait_drain("s5 drained");

        // Bring ptr to 2, then src3 (1 beat) must beat src0 (2 beats)
        push(2, 8'h70, 1'b1);
        expect_beat(8'h70, 1'b1, 2'd2);
        drive(); #1;
        step();
        push(0, 8'h80, 1'b0); push(0, 8'h81, 1'b1); push(3, 8'h83, 1'b1);
        expect_beat(8'h83, 1'b1, 2'd3);
        expect_beat(8'h80, 1'b0, 2'd0);
        expect_beat(8'h81, 1'b1, 2'd0);
        drive(); #1;
        check("s6 locked ready_src", ready_src, 4'b0100);
        wait_drain("s6 drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
